rotation_checker: RTL
=====================

ROTATION_CHECKER -- requirements
Module: rotation_checker

Interface
REQ-001 Parameter BOARD_W, default 10, board width in cells.
REQ-002 Parameter BOARD_H, default 20, board height in cells.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 chk_valid  input  1  candidate placement offered.
REQ-006 chk_ready  output  1  block can accept a candidate.
REQ-007 chk_x  input  20  candidate x coords, cell i at [5i+4:5i], unsigned.
REQ-008 chk_y  input  20  candidate y coords, same packing.
REQ-009 chk_orientation  input  orientation  candidate orientation, passed through.
REQ-010 board_rd_en  output  1  board read strobe.
REQ-011 board_row  output  5  board read row.
REQ-012 board_col  output  4  board read column.
REQ-013 board_rdata  input  block_color  board cell contents, valid the cycle after board_rd_en.
REQ-014 res_valid  output  1  one-cycle result pulse.
REQ-015 res_ok  output  1  1 = placement legal; 0 = rejected.
REQ-016 res_x, res_y  output  20 each  final checked coords.
REQ-017 res_orientation  output  orientation  captured chk_orientation.

Function
REQ-018 Handshake: transfer on rising edge with chk_valid && chk_ready; chk_ready SHALL be 1 only in IDLE.
REQ-019 chk_x, chk_y, chk_orientation SHALL be registered at transfer; later input changes ignored.
REQ-020 FSM states: IDLE, READ (4 cycles, cell index 0..3), EVAL (1 cycle), RESP (1 cycle), then IDLE.
REQ-021 Transfer edge = cycle 0; cell i read issued in cycle i+1, its data sampled in cycle i+2.
REQ-022 A cell is out of bounds when x >= BOARD_W or y >= BOARD_H; no read SHALL be issued for it (board_rd_en 0 that cycle) and it SHALL count as a collision.
REQ-023 An in-bounds cell collides when board_rdata != EMPTY.
REQ-024 Attempt legal only if none of the 4 cells collide; checking SHALL NOT terminate early.
REQ-025 Without kicks, res_valid SHALL pulse in cycle 6 after transfer, with res_ok, res_x, res_y, res_orientation valid that cycle only.
REQ-026 board_row/board_col SHALL be 0 whenever board_rd_en is 0.
REQ-027 Coordinate arithmetic SHALL be 5-bit modulo; 0 - 1 = 31, hence out of bounds.
REQ-028 Duplicate cells within a candidate SHALL be checked independently, no special handling.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, chk_ready 1 after release, board_rd_en 0, res_valid 0, res_ok 0, res_x/res_y 0, res_orientation to the package's first orientation value.
REQ-030 Reset mid-attempt SHALL discard the candidate; no res_valid for it.

Configuration
REQ-031 Macro ROTATION_CHECKER_WALL_KICK_EN defined: on failed attempt, retry with all x shifted -1, then +1 (relative to original), reads of next attempt starting the cycle after EVAL; res_valid in cycle 6, 11 or 16; res_x reports the accepted shift, or the +1 shift if all three fail.
REQ-032 Macro undefined: single attempt only, latency always 6.

Structure
REQ-033 Package types SHALL hold block_color (including EMPTY), orientation, BOARD_W/BOARD_H defaults, and CELL_BITS = 5.
REQ-034 No sub-module; FSM, cell mux and bounds check live in rotation_checker.

Verification
REQ-035 Empty board, x={3,4,5,6}, y={0,0,0,0} -> res_valid cycle 6, res_ok 1, reads (0,3),(0,4),(0,5),(0,6).
REQ-036 Cell (0,5) = CYAN, same candidate -> res_ok 0 at cycle 6 (kick off); with kick, shift -1 hits (0,5), +1 hits (0,5) -> res_ok 0 at cycle 16.
REQ-037 x={9,10,9,9} empty board -> cell 1 skipped (board_rd_en 0 in cycle 2), res_ok 0; with kick, -1 shift legal -> res_ok 1, res_x cells {8,9,8,8}, cycle 11.
REQ-038 x={0,0,0,0} with kick, (y,0) occupied -> -1 gives 31 out of bounds, +1 legal -> res_ok 1 cycle 16.
REQ-039 reset_n low in cycle 3 -> no res_valid ever, board_rd_en 0 immediately, chk_ready 1 first cycle after release.
REQ-040 chk_valid held high continuously -> one transfer per completed result, chk_ready 0 throughout READ/EVAL/RESP.

Source files
------------

// File: rtl/rotation_checker_pkg.sv
// Shared types and constants for the rotation checker: cell colours, piece
// orientations, board defaults and the FSM state encoding.
package rotation_checker_pkg;

  localparam int unsigned CELL_BITS   = 5;
  localparam int unsigned BOARD_W_DEF = 10;
  localparam int unsigned BOARD_H_DEF = 20;

  typedef enum logic [2:0] {
    EMPTY,
    CYAN,
    YELLOW,
    PURPLE,
    GREEN,
    RED,
    BLUE,
    ORANGE
  } block_color;

  typedef enum logic [1:0] {
    ORIENT_0,
    ORIENT_R,
    ORIENT_2,
    ORIENT_L
  } orientation;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_RESP
  } chk_state_e;

  // Adds the same 5-bit offset to all four packed coordinates (modulo 32).
  function automatic logic [4*CELL_BITS-1:0] shift_cells(
    input logic [4*CELL_BITS-1:0] x,
    input logic [CELL_BITS-1:0]   off
  );
    logic [4*CELL_BITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[i*CELL_BITS +: CELL_BITS] = x[i*CELL_BITS +: CELL_BITS] + off;
    end
    return r;
  endfunction

endpackage

// File: rtl/rotation_checker.sv
// Checks a four-cell piece placement against the board, one cell read per cycle.
// Define ROTATION_CHECKER_WALL_KICK_EN to retry failed placements shifted x-1, then x+1.
module rotation_checker
  import rotation_checker_pkg::*;
#(
  parameter int unsigned BOARD_W = BOARD_W_DEF,
  parameter int unsigned BOARD_H = BOARD_H_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chk_valid,
  output logic        chk_ready,
  input  logic [19:0] chk_x,
  input  logic [19:0] chk_y,
  input  orientation  chk_orientation,
  output logic        board_rd_en,
  output logic [4:0]  board_row,
  output logic [3:0]  board_col,
  input  block_color  board_rdata,
  output logic        res_valid,
  output logic        res_ok,
  output logic [19:0] res_x,
  output logic [19:0] res_y,
  output orientation  res_orientation
);

  chk_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  att_q, att_d;
  logic        coll_q, coll_d;
  logic        pend_q, pend_d;
  logic [19:0] x_q, x_d;
  logic [19:0] y_q, y_d;
  orientation  orient_q, orient_d;
  logic        res_ok_q, res_ok_d;
  logic [19:0] res_x_q, res_x_d;
  logic [19:0] res_y_q, res_y_d;

  logic [4:0]  off;
  logic [19:0] xs;
  logic [4:0]  cx, cy;
  logic        oob, hit, fail, kick_left, rd_en;

  // Attempt 0 uses the original x, attempt 1 shifts by -1, attempt 2 by +1.
  always_comb begin
    unique case (att_q)
      2'd1:    off = 5'd31;
      2'd2:    off = 5'd1;
      default: off = 5'd0;
    endcase
    xs = shift_cells(x_q, off);
  end

  always_comb begin
    unique case (idx_q)
      2'd0: begin cx = xs[4:0];   cy = y_q[4:0];   end
      2'd1: begin cx = xs[9:5];   cy = y_q[9:5];   end
      2'd2: begin cx = xs[14:10]; cy = y_q[14:10]; end
      default: begin cx = xs[19:15]; cy = y_q[19:15]; end
    endcase
    oob = ({27'd0, cx} >= BOARD_W) || ({27'd0, cy} >= BOARD_H);
  end

`ifdef ROTATION_CHECKER_WALL_KICK_EN
  assign kick_left = (att_q != 2'd2);
`else
  assign kick_left = 1'b0;
`endif

  // pend_q marks that last cycle issued a read, so board_rdata is meaningful now.
  assign hit = pend_q && (board_rdata != EMPTY);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    att_d    = att_q;
    coll_d   = coll_q;
    pend_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    orient_d = orient_q;
    res_ok_d = res_ok_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    rd_en    = 1'b0;
    fail     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (chk_valid) begin
          x_d      = chk_x;
          y_d      = chk_y;
          orient_d = chk_orientation;
          att_d    = 2'd0;
          idx_d    = 2'd0;
          coll_d   = 1'b0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        rd_en  = !oob;
        pend_d = !oob;
        coll_d = coll_q | hit | oob;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        // Cell 3 data arrives here, so the verdict folds in this cycle's hit.
        fail = coll_q | hit;
        if (fail && kick_left) begin
          att_d   = att_q + 2'd1;
          idx_d   = 2'd0;
          coll_d  = 1'b0;
          state_d = ST_READ;
        end else begin
          res_ok_d = !fail;
          res_x_d  = xs;
          res_y_d  = y_q;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      att_q    <= '0;
      coll_q   <= 1'b0;
      pend_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      orient_q <= ORIENT_0;
      res_ok_q <= 1'b0;
      res_x_q  <= '0;
      res_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      att_q    <= att_d;
      coll_q   <= coll_d;
      pend_q   <= pend_d;
      x_q      <= x_d;
      y_q      <= y_d;
      orient_q <= orient_d;
      res_ok_q <= res_ok_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
    end
  end

  assign chk_ready       = (state_q == ST_IDLE);
  assign board_rd_en     = rd_en;
  assign board_row       = rd_en ? cy : '0;
  assign board_col       = rd_en ? cx[3:0] : '0;
  assign res_valid       = (state_q == ST_RESP);
  assign res_ok          = res_ok_q;
  assign res_x           = res_x_q;
  assign res_y           = res_y_q;
  assign res_orientation = orient_q;

endmodule
